// File: rtl/ws_pkg.sv
// Shared types and geometry helpers for the sliding-window frame sequencer.
package ws_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    FEED  = 3'd2,
    OFFER = 3'd3,
    FIN   = 3'd4
  } ws_seq_state_t;

  // Row/column positions share the width of the win_row/win_col ports.
  localparam int unsigned POS_W = 8;

  function automatic int unsigned ws_window_count(input int unsigned rows,
                                                  input int unsigned cols,
                                                  input int unsigned k,
                                                  input int unsigned s);
    return ((rows - k) / s + 1) * ((cols - k) / s + 1);
  endfunction

  // True when a window whose last row/col is pos lies on the stride grid.
  function automatic logic ws_on_grid(input logic [POS_W-1:0] pos,
                                      input int unsigned k,
                                      input int unsigned s);
    int unsigned p;
    p = 32'(pos);
    return (p >= k - 1) && (((p - (k - 1)) % s) == 0);
  endfunction

endpackage

// File: rtl/ws_pos_counter.sv
// Row-major pixel position tracker: pixel index plus row/col, with wrap flags.
module ws_pos_counter
  import ws_pkg::*;
#(
  parameter int unsigned ROWS  = 32,
  parameter int unsigned COLS  = 32,
  parameter int unsigned PIX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [PIX_W-1:0] pix,
  output logic [POS_W-1:0] row,
  output logic [POS_W-1:0] col,
  output logic             col_wrap,
  output logic             last
);

  assign col_wrap = (col == POS_W'(COLS - 1));
  assign last     = (pix == PIX_W'(ROWS * COLS - 1));

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      pix <= '0;
      row <= '0;
      col <= '0;
    end else if (inc) begin
      pix <= pix + PIX_W'(1);
      if (col_wrap) begin
        col <= '0;
        row <= row + POS_W'(1);
      end else begin
        col <= col + POS_W'(1);
      end
    end
  end

endmodule

// File: rtl/ws_frame_sequencer.sv
// Streams an image from single-port RAM one pixel per two cycles and offers
// each completed KxK window (stride S) to a downstream consumer.
module ws_frame_sequencer
  import ws_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned DATA_ADDR_WIDTH = 10,
  parameter int unsigned IMAGE_ROW_LEN   = 32,
  parameter int unsigned IMAGE_COL_LEN   = 32,
  parameter int unsigned KERNEL_SIZE     = 3,
  parameter int unsigned STRIDE          = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       host_wen,
  input  logic [DATA_ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0]      host_wdata,
  output logic                       host_ack,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       ram_wen,
  output logic                       ram_ren,
  output logic [DATA_ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]      ram_wdata,
  input  logic [DATA_WIDTH-1:0]      ram_rdata,
  output logic                       feed_en,
  output logic                       pixel_out,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [7:0]                 win_row,
  output logic [7:0]                 win_col
);

  localparam int unsigned NUM_WINDOWS =
    ws_window_count(IMAGE_ROW_LEN, IMAGE_COL_LEN, KERNEL_SIZE, STRIDE);

  // Reject geometries that cannot be addressed or produce no windows.
  if (IMAGE_ROW_LEN * IMAGE_COL_LEN > (1 << DATA_ADDR_WIDTH) ||
      KERNEL_SIZE > IMAGE_ROW_LEN || KERNEL_SIZE > IMAGE_COL_LEN ||
      STRIDE == 0 || NUM_WINDOWS == 0) begin : g_geometry_check
    $error("ws_frame_sequencer: unsupported image/kernel geometry");
  end

  ws_seq_state_t              state;
  logic [DATA_ADDR_WIDTH-1:0] pix;
  logic [POS_W-1:0]           row;
  logic [POS_W-1:0]           col;
  logic                       col_wrap;
  logic                       last;
  logic                       cnt_clr;
  logic                       cnt_inc;
  logic                       win_hit;
  logic                       unused_ok;

  ws_pos_counter #(
    .ROWS  (IMAGE_ROW_LEN),
    .COLS  (IMAGE_COL_LEN),
    .PIX_W (DATA_ADDR_WIDTH)
  ) u_pos (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .pix      (pix),
    .row      (row),
    .col      (col),
    .col_wrap (col_wrap),
    .last     (last)
  );

  // Only bit 0 of the RAM word feeds the window datapath.
  assign unused_ok = ^{col_wrap, ram_rdata};

  assign win_hit = ws_on_grid(row, KERNEL_SIZE, STRIDE) &&
                   ws_on_grid(col, KERNEL_SIZE, STRIDE);

  // The position advances only when the current pixel is fully retired.
  assign cnt_clr = (state == IDLE) && start;
  assign cnt_inc = !last && (((state == FEED) && !win_hit) ||
                             ((state == OFFER) && win_ready));

  // Host owns the RAM port whenever the sequencer is idle.
  assign host_ack  = host_wen & ~busy;
  assign ram_wen   = host_ack;
  assign ram_addr  = busy ? pix : host_addr;
  assign ram_wdata = busy ? '0 : host_wdata;
  assign pixel_out = feed_en & ram_rdata[0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_ren   <= 1'b0;
      feed_en   <= 1'b0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else begin
      done    <= 1'b0;
      ram_ren <= 1'b0;
      feed_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= READ;
            busy    <= 1'b1;
            ram_ren <= 1'b1;
          end
        end
        READ: begin
          state   <= FEED;
          feed_en <= 1'b1;
        end
        FEED: begin
          if (win_hit) begin
            state     <= OFFER;
            win_valid <= 1'b1;
            win_row   <= row - POS_W'(KERNEL_SIZE - 1);
            win_col   <= col - POS_W'(KERNEL_SIZE - 1);
          end else if (last) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            state   <= READ;
            ram_ren <= 1'b1;
          end
        end
        OFFER: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            if (last) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state   <= READ;
              ram_ren <= 1'b1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ws_frame_sequencer.md
WS_FRAME_SEQUENCER -- requirements
Module: ws_frame_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, image RAM word width.
REQ-002 SHALL have parameter DATA_ADDR_WIDTH, default 10, image RAM address width.
REQ-003 SHALL have parameter IMAGE_ROW_LEN, default 32, image rows (R).
REQ-004 SHALL have parameter IMAGE_COL_LEN, default 32, image columns (C).
REQ-005 SHALL have parameter KERNEL_SIZE, default 3, window edge (K).
REQ-006 SHALL have parameter STRIDE, default 1, window step (S).
REQ-007 SHALL have port clk, input, 1, clock.
REQ-008 SHALL have port rst, input, 1, reset; synchronous, active-low.
REQ-009 SHALL have ports host_wen (input, 1), host_addr (input, DATA_ADDR_WIDTH) and host_wdata (input, DATA_WIDTH): host image-load write request.
REQ-010 SHALL have port host_ack, output, 1, host write accepted this cycle.
REQ-011 SHALL have ports start (input, 1), busy (output, 1) and done (output, 1): frame control.
REQ-012 SHALL have ports ram_wen (output, 1), ram_ren (output, 1), ram_addr (output, DATA_ADDR_WIDTH), ram_wdata (output, DATA_WIDTH) and ram_rdata (input, DATA_WIDTH): single-port RAM, read latency 1.
REQ-013 SHALL have ports feed_en (output, 1) and pixel_out (output, 1): one pixel shift into the window datapath.
REQ-014 SHALL have ports win_valid (output, 1), win_ready (input, 1), win_row (output, 8) and win_col (output, 8): window-offer handshake.

Function
REQ-015 SHALL implement FSM states IDLE, READ, FEED, OFFER and FIN.
REQ-016 IDLE->READ on start=1; start SHALL be ignored in any other state.
REQ-017 In READ, SHALL assert ram_ren=1 with ram_addr=p (pixel index, 0..R*C-1, row-major), then go to FEED.
REQ-018 In FEED, SHALL assert feed_en=1 with pixel_out=ram_rdata[0]; pixel p sits at r=p/C, c=p%C.
REQ-019 In FEED, a window completes when r>=K-1, c>=K-1, (r-K+1)%S==0 and (c-K+1)%S==0; if complete, SHALL go to OFFER, otherwise to READ (or FIN when p=R*C-1).
REQ-020 In OFFER, SHALL assert win_valid=1 with win_row=r-K+1 and win_col=c-K+1, held stable until win_ready=1; the transfer completes on the cycle with win_valid&win_ready, then SHALL go to READ, or to FIN when p=R*C-1.
REQ-021 win_ready outside OFFER SHALL be ignored; no RAM read SHALL be issued while in OFFER.
REQ-022 FIN SHALL pulse done=1 for exactly one cycle, then go to IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 Pixel index and row/col counters SHALL reset to 0 on entry to READ from IDLE; col SHALL wrap C-1->0 with row increment.
REQ-025 ram_wen=host_ack=host_wen&~busy (combinational); ram_addr=host_addr and ram_wdata=host_wdata while busy=0; host writes during busy SHALL be refused (host holds its request).
REQ-026 Throughput SHALL be one pixel per 2 cycles without backpressure; frame length SHALL be 2*R*C + (number of windows) + 1 cycles from start accept to done, with win_ready tied to 1.

Reset
REQ-027 On rst=0, SHALL enter IDLE with busy, done, ram_ren, feed_en, win_valid, pixel_out, ram_addr, win_row and win_col all 0, at any point including mid-frame.
REQ-028 After reset, SHALL accept start on the first cycle in which rst=1.

Structure
REQ-029 ws_pkg SHALL hold the state enum ws_seq_state_t and a function returning the window count ((R-K)/S+1)*((C-K)/S+1).
REQ-030 Row/col/pixel counting SHALL live in sub-module ws_pos_counter (inc, clr, wrap flags).

Verification
REQ-031 Defaults, win_ready=1, start at cycle 0 -> first win_valid at cycle 135 with row=0, col=0; 900 windows; last offer row=29, col=29; one-cycle done.
REQ-032 STRIDE=2 -> 225 windows; all offers have even row and even col; last offer row=28, col=28.
REQ-033 win_ready held 0 for 5 cycles during an offer -> win_valid, win_row and win_col stable; ram_ren=0 throughout.
REQ-034 host_wen=1 while busy -> host_ack=0 and ram_wen=0; the same write issued in IDLE -> ram_wen=1 in the same cycle.
REQ-035 rst=0 at pixel 500 -> all outputs 0 next cycle; a new start gives first offer row=0, col=0.
REQ-036 start pulsed while busy -> no effect; window count unchanged at 900.
